// File: rtl/cheshire_dma_2d_pkg.sv
// Shared types for the 2D DMA unroll mid-end: FSM states and the 2D job descriptor.
package cheshire_dma_2d_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned REP_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } unroll_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  length;
    logic [REP_W-1:0]  reps;
    logic [REP_W-1:0]  src_stride;
    logic [REP_W-1:0]  dst_stride;
  } nd_job_t;

endpackage

// File: rtl/cheshire_dma_2d_addr_gen.sv
// Running row addresses of a 2D job: loaded with the bases, stepped by the
// sign-extended strides (wrapping modulo 2^AddrWidth).
module cheshire_dma_2d_addr_gen
  import cheshire_dma_2d_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_W,
  parameter int unsigned RepWidth  = REP_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load,
  input  logic                 step,
  input  logic [AddrWidth-1:0] src_base,
  input  logic [AddrWidth-1:0] dst_base,
  input  logic [RepWidth-1:0]  src_stride,
  input  logic [RepWidth-1:0]  dst_stride,
  output logic [AddrWidth-1:0] src_addr,
  output logic [AddrWidth-1:0] dst_addr
);

  logic [AddrWidth-1:0] src_addr_r;
  logic [AddrWidth-1:0] dst_addr_r;
  logic [RepWidth-1:0]  src_stride_r;
  logic [RepWidth-1:0]  dst_stride_r;

  function automatic logic [AddrWidth-1:0] sext(input logic [RepWidth-1:0] v);
    return {{(AddrWidth-RepWidth){v[RepWidth-1]}}, v};
  endfunction

  // Address and stride registers: load on job accept, advance on each issued row.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_addr_r   <= {AddrWidth{1'b0}};
      dst_addr_r   <= {AddrWidth{1'b0}};
      src_stride_r <= {RepWidth{1'b0}};
      dst_stride_r <= {RepWidth{1'b0}};
    end else if (load) begin
      src_addr_r   <= src_base;
      dst_addr_r   <= dst_base;
      src_stride_r <= src_stride;
      dst_stride_r <= dst_stride;
    end else if (step) begin
      src_addr_r <= src_addr_r + sext(src_stride_r);
      dst_addr_r <= dst_addr_r + sext(dst_stride_r);
    end
  end

  assign src_addr = src_addr_r;
  assign dst_addr = dst_addr_r;

endmodule

// File: rtl/cheshire_dma_2d_unroll.sv
// Unrolls one 2D DMA job into 1D burst requests, counts backend completions
// and returns a single job response carrying the OR of all row errors.
module cheshire_dma_2d_unroll
  import cheshire_dma_2d_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_W,
  parameter int unsigned LenWidth  = LEN_W,
  parameter int unsigned RepWidth  = REP_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 nd_valid_i,
  output logic                 nd_ready_o,
  input  logic [AddrWidth-1:0] nd_src_addr_i,
  input  logic [AddrWidth-1:0] nd_dst_addr_i,
  input  logic [LenWidth-1:0]  nd_length_i,
  input  logic [RepWidth-1:0]  nd_reps_i,
  input  logic [RepWidth-1:0]  nd_src_stride_i,
  input  logic [RepWidth-1:0]  nd_dst_stride_i,
  output logic                 burst_valid_o,
  input  logic                 burst_ready_i,
  output logic [AddrWidth-1:0] burst_src_addr_o,
  output logic [AddrWidth-1:0] burst_dst_addr_o,
  output logic [LenWidth-1:0]  burst_length_o,
  output logic                 burst_last_o,
  input  logic                 burst_rsp_valid_i,
  input  logic                 burst_rsp_error_i,
  output logic                 burst_rsp_ready_o,
  output logic                 nd_rsp_valid_o,
  output logic                 nd_rsp_error_o,
  input  logic                 nd_rsp_ready_i,
  output logic                 busy_o
);

  unroll_state_e         state_r, state_s;
  logic [LenWidth-1:0]   length_r;
  logic [RepWidth:0]     reps_eff_r;
  logic [RepWidth:0]     issue_cnt_r;
  logic [RepWidth:0]     rsp_cnt_r;
  logic [RepWidth:0]     rsp_cnt_next_s;
  logic                  err_r;
  logic                  accept_s;
  logic                  burst_hs_s;
  logic                  count_rsp_s;
  logic                  last_row_s;

  assign accept_s       = (state_r == IDLE) && nd_valid_i;
  assign burst_hs_s     = (state_r == ISSUE) && burst_ready_i;
  assign count_rsp_s    = ((state_r == ISSUE) || (state_r == DRAIN)) && burst_rsp_valid_i;
  assign last_row_s     = (issue_cnt_r == (reps_eff_r - (RepWidth+1)'(1)));
  assign rsp_cnt_next_s = rsp_cnt_r + (RepWidth+1)'(count_rsp_s);

  cheshire_dma_2d_addr_gen #(
    .AddrWidth (AddrWidth),
    .RepWidth  (RepWidth)
  ) i_addr_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load       (accept_s),
    .step       (burst_hs_s),
    .src_base   (nd_src_addr_i),
    .dst_base   (nd_dst_addr_i),
    .src_stride (nd_src_stride_i),
    .dst_stride (nd_dst_stride_i),
    .src_addr   (burst_src_addr_o),
    .dst_addr   (burst_dst_addr_o)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DRAIN exits on the cycle the final completion arrives.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (nd_valid_i) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (burst_ready_i && last_row_s) state_s = DRAIN; else state_s = ISSUE;
      DRAIN:   if (rsp_cnt_next_s == reps_eff_r) state_s = RESP; else state_s = DRAIN;
      RESP:    if (nd_rsp_ready_i) state_s = IDLE; else state_s = RESP;
      default: state_s = IDLE;
    endcase
  end

  // Job fields, row/completion counters and the sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      length_r    <= {LenWidth{1'b0}};
      reps_eff_r  <= {(RepWidth+1){1'b0}};
      issue_cnt_r <= {(RepWidth+1){1'b0}};
      rsp_cnt_r   <= {(RepWidth+1){1'b0}};
      err_r       <= 1'b0;
    end else if (accept_s) begin
      length_r    <= nd_length_i;
      reps_eff_r  <= (nd_reps_i == {RepWidth{1'b0}}) ? (RepWidth+1)'(1) : {1'b0, nd_reps_i};
      issue_cnt_r <= {(RepWidth+1){1'b0}};
      rsp_cnt_r   <= {(RepWidth+1){1'b0}};
      err_r       <= 1'b0;
    end else begin
      if (burst_hs_s) begin
        issue_cnt_r <= issue_cnt_r + (RepWidth+1)'(1);
      end
      if (count_rsp_s) begin
        rsp_cnt_r <= rsp_cnt_next_s;
        err_r     <= err_r | burst_rsp_error_i;
      end
    end
  end

  // Handshake outputs decoded from state and registers only.
  always_comb begin
    nd_ready_o     = (state_r == IDLE);
    burst_valid_o  = (state_r == ISSUE);
    burst_last_o   = (state_r == ISSUE) && last_row_s;
    nd_rsp_valid_o = (state_r == RESP);
    nd_rsp_error_o = (state_r == RESP) && err_r;
    busy_o         = (state_r != IDLE);
  end

  assign burst_length_o    = length_r;
  assign burst_rsp_ready_o = 1'b1;

endmodule

// File: tb/tb_cheshire_dma_2d_unroll.sv
// Directed bench: expected bursts and completions are queued when a job is
// driven and compared as the DUT produces them.
module tb_cheshire_dma_2d_unroll;
  import cheshire_dma_2d_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        nd_valid_i;
  logic        nd_ready_o;
  logic [63:0] nd_src_addr_i, nd_dst_addr_i;
  logic [31:0] nd_length_i, nd_reps_i, nd_src_stride_i, nd_dst_stride_i;
  logic        burst_valid_o, burst_ready_i;
  logic [63:0] burst_src_addr_o, burst_dst_addr_o;
  logic [31:0] burst_length_o;
  logic        burst_last_o;
  logic        burst_rsp_valid_i, burst_rsp_error_i, burst_rsp_ready_o;
  logic        nd_rsp_valid_o, nd_rsp_error_o, nd_rsp_ready_i;
  logic        busy_o;

  cheshire_dma_2d_unroll dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .nd_valid_i        (nd_valid_i),
    .nd_ready_o        (nd_ready_o),
    .nd_src_addr_i     (nd_src_addr_i),
    .nd_dst_addr_i     (nd_dst_addr_i),
    .nd_length_i       (nd_length_i),
    .nd_reps_i         (nd_reps_i),
    .nd_src_stride_i   (nd_src_stride_i),
    .nd_dst_stride_i   (nd_dst_stride_i),
    .burst_valid_o     (burst_valid_o),
    .burst_ready_i     (burst_ready_i),
    .burst_src_addr_o  (burst_src_addr_o),
    .burst_dst_addr_o  (burst_dst_addr_o),
    .burst_length_o    (burst_length_o),
    .burst_last_o      (burst_last_o),
    .burst_rsp_valid_i (burst_rsp_valid_i),
    .burst_rsp_error_i (burst_rsp_error_i),
    .burst_rsp_ready_o (burst_rsp_ready_o),
    .nd_rsp_valid_o    (nd_rsp_valid_o),
    .nd_rsp_error_o    (nd_rsp_error_o),
    .nd_rsp_ready_i    (nd_rsp_ready_i),
    .busy_o            (busy_o)
  );

  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
    logic        last;
  } burst_t;

  typedef struct {
    int   due;
    logic err;
  } rsp_t;

  burst_t exp_q[$];
  rsp_t   rsp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_delay, err_idx, hold, rsp_seen, issued_idx, rsps_driven;
  int   cur_reps, final_cyc, last_hs, accept_cyc;
  bit   rnd_ready, done;
  logic exp_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_nd_ready"}, 64'(nd_ready_o), 64'd1);
    check({tag, "_burst_valid"}, 64'(burst_valid_o), 64'd0);
    check({tag, "_burst_last"}, 64'(burst_last_o), 64'd0);
    check({tag, "_rsp_valid"}, 64'(nd_rsp_valid_o), 64'd0);
    check({tag, "_rsp_error"}, 64'(nd_rsp_error_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_bresp_ready"}, 64'(burst_rsp_ready_o), 64'd1);
    check({tag, "_src"}, burst_src_addr_o, 64'd0);
    check({tag, "_dst"}, burst_dst_addr_o, 64'd0);
    check({tag, "_len"}, 64'(burst_length_o), 64'd0);
  endtask

  // One cycle: observe outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    burst_t b;
    rsp_t   r;
    @(negedge clk);
    cyc++;
    burst_rsp_valid_i = 1'b0;
    burst_rsp_error_i = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      burst_rsp_valid_i = 1'b1;
      burst_rsp_error_i = r.err;
      rsps_driven++;
      if (rsps_driven == cur_reps) final_cyc = cyc;
    end
    burst_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (burst_valid_o) begin
      check("burst_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        b = exp_q[0];
        check("burst_src", burst_src_addr_o, b.src);
        check("burst_dst", burst_dst_addr_o, b.dst);
        check("burst_len", 64'(burst_length_o), 64'(b.len));
        check("burst_last", 64'(burst_last_o), 64'(b.last));
        if (burst_ready_i) begin
          void'(exp_q.pop_front());
          r.due = cyc + rsp_delay;
          r.err = (issued_idx == err_idx);
          rsp_q.push_back(r);
          issued_idx++;
          last_hs = cyc;
        end
      end
    end
    nd_rsp_ready_i = 1'b0;
    if (nd_rsp_valid_o) begin
      check("resp_nd_ready", 64'(nd_ready_o), 64'd0);
      check("resp_busy", 64'(busy_o), 64'd1);
      if (rsp_seen == 0) check("rsp_latency", 64'(cyc), 64'(final_cyc + 1));
      rsp_seen++;
      if (rsp_seen > hold) begin
        nd_rsp_ready_i = 1'b1;
        check("nd_rsp_error", 64'(nd_rsp_error_o), 64'(exp_err));
        done = 1'b1;
      end
    end
  endtask

  task automatic start_job(input nd_job_t j, input int delay, input bit rnd,
                           input int eidx, input int hold_cycles, input logic eerr);
    logic [63:0] s, d;
    burst_t b;
    tick();
    check("idle_nd_ready", 64'(nd_ready_o), 64'd1);
    check("idle_busy", 64'(busy_o), 64'd0);
    cur_reps = (j.reps == 32'd0) ? 1 : int'(j.reps);
    rsp_delay = delay; rnd_ready = rnd; err_idx = eidx; hold = hold_cycles; exp_err = eerr;
    rsp_seen = 0; done = 1'b0; issued_idx = 0; rsps_driven = 0; final_cyc = -10; last_hs = -1;
    s = j.src;
    d = j.dst;
    for (int i = 0; i < cur_reps; i++) begin
      b.src = s; b.dst = d; b.len = j.length; b.last = (i == cur_reps - 1);
      exp_q.push_back(b);
      s = s + {{32{j.src_stride[31]}}, j.src_stride};
      d = d + {{32{j.dst_stride[31]}}, j.dst_stride};
    end
    nd_src_addr_i = j.src; nd_dst_addr_i = j.dst; nd_length_i = j.length;
    nd_reps_i = j.reps; nd_src_stride_i = j.src_stride; nd_dst_stride_i = j.dst_stride;
    nd_valid_i = 1'b1;
    accept_cyc = cyc;
    tick();
    nd_valid_i = 1'b0;
    check("first_burst_latency", 64'(burst_valid_o), 64'd1);
    check("busy_after_accept", 64'(busy_o), 64'd1);
  endtask

  task automatic finish_job();
    int guard = 0;
    while (!done && guard < 1000) begin
      tick();
      guard++;
    end
    check("job_done", 64'(done), 64'd1);
    check("bursts_all_issued", 64'(exp_q.size()), 64'd0);
    if (!rnd_ready) check("issue_rate", 64'(last_hs), 64'(accept_cyc + cur_reps));
  endtask

  initial begin
    nd_job_t j;
    rst_ni = 1'b0; nd_valid_i = 1'b0; nd_rsp_ready_i = 1'b0;
    burst_ready_i = 1'b0; burst_rsp_valid_i = 1'b0; burst_rsp_error_i = 1'b0;
    nd_src_addr_i = 64'd0; nd_dst_addr_i = 64'd0; nd_length_i = 32'd0;
    nd_reps_i = 32'd0; nd_src_stride_i = 32'd0; nd_dst_stride_i = 32'd0;
    rnd_ready = 1'b0; rsp_delay = 1; err_idx = -1; hold = 0; cur_reps = 1;
    final_cyc = -10; rsp_seen = 0; rsps_driven = 0; issued_idx = 0;
    tick(); tick();
    check_reset("por");
    rst_ni = 1'b1;

    // Basic 4-row job, responses 3 cycles after each issue.
    j = '{src: 64'h1000, dst: 64'h8000, length: 32'd64, reps: 32'd4,
          src_stride: 32'h100, dst_stride: 32'h40};
    start_job(j, 3, 1'b0, -1, 0, 1'b0);
    finish_job();

    // reps == 0 behaves as a single row.
    j = '{src: 64'h2000, dst: 64'h3000, length: 32'd16, reps: 32'd0,
          src_stride: 32'h10, dst_stride: 32'h10};
    start_job(j, 1, 1'b0, -1, 0, 1'b0);
    finish_job();

    // Negative source stride.
    j = '{src: 64'h100, dst: 64'h500, length: 32'd8, reps: 32'd3,
          src_stride: 32'hFFFF_FFF0, dst_stride: 32'h20};
    start_job(j, 2, 1'b0, -1, 0, 1'b0);
    finish_job();

    // Random backpressure; second completion reports an error.
    j = '{src: 64'hFFFF_FFFF_FFFF_FF00, dst: 64'h4000, length: 32'd32, reps: 32'd5,
          src_stride: 32'h80, dst_stride: 32'hFFFF_FF00};
    start_job(j, 2, 1'b1, 1, 0, 1'b1);
    finish_job();

    // Completion coincides with issue of row 2; consumer stalls 5 cycles.
    j = '{src: 64'h5000, dst: 64'h6000, length: 32'd4, reps: 32'd3,
          src_stride: 32'h4, dst_stride: 32'h8};
    start_job(j, 2, 1'b0, -1, 5, 1'b0);
    finish_job();
    check("rsp_hold_cycles", 64'(rsp_seen), 64'd6);

    // Reset in the middle of an 8-row job.
    j = '{src: 64'h7000, dst: 64'h9000, length: 32'd128, reps: 32'd8,
          src_stride: 32'h200, dst_stride: 32'h200};
    start_job(j, 3, 1'b0, -1, 0, 1'b0);
    tick(); tick();
    rst_ni = 1'b0;
    tick();
    check_reset("midjob");
    exp_q.delete();
    rsp_q.delete();
    burst_rsp_valid_i = 1'b0;
    burst_rsp_error_i = 1'b0;
    rst_ni = 1'b1;

    j = '{src: 64'hA000, dst: 64'hB000, length: 32'd12, reps: 32'd2,
          src_stride: 32'h40, dst_stride: 32'h40};
    start_job(j, 1, 1'b0, -1, 0, 1'b0);
    finish_job();

    tick();
    check("final_idle", 64'(nd_ready_o), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
